// File: rtl/alu_op_issue.sv
// Operation issue buffer in front of the ALU: a valid/ready FIFO feeding a registered issue stage.
// Optional 16-bit issued-operation counter is enabled with `define ALU_ISSUE_PERF_EN.
module alu_op_issue #(
   parameter int DEPTH = 4,
   parameter int OPW   = 4,
   parameter int CODEW = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CODEW-1:0]         in_opcode,
   input  logic [OPW-1:0]           in_op1,
   input  logic [OPW-1:0]           in_op2,
   input  logic                     alu_busy,
   output logic [CODEW-1:0]         OPCODE,
   output logic [OPW-1:0]           OP1,
   output logic [OPW-1:0]           OP2,
   output logic                     alu_valid,
   output logic [$clog2(DEPTH):0]   count
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [15:0]              issue_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = CODEW + 2 * OPW;
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_not_full;
   logic          w_push;
   logic          w_pop;
   logic          w_wr_en;
   logic [EW-1:0] w_in_entry;
   logic [EW-1:0] w_head;

   assign w_not_full = (r_count != CNT_FULL);
   assign w_push     = in_valid && w_not_full;
   assign w_pop      = !alu_busy && (r_count != CNT_ZERO);
   // A push offered during reset or flush is squashed, so it must not touch storage either.
   assign w_wr_en    = w_push && !flush && !rst;
   assign w_in_entry = {in_opcode, in_op1, in_op2};
   assign w_head     = r_mem[r_rptr];

   assign in_ready   = w_not_full;
   assign count      = r_count;

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wptr] <= w_in_entry;
      end
   end

   // Pointers, occupancy and the registered issue stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr    <= {AW{1'b0}};
         r_rptr    <= {AW{1'b0}};
         r_count   <= CNT_ZERO;
         alu_valid <= 1'b0;
         OPCODE    <= {CODEW{1'b0}};
         OP1       <= {OPW{1'b0}};
         OP2       <= {OPW{1'b0}};
      end else if (flush) begin
         r_wptr    <= {AW{1'b0}};
         r_rptr    <= {AW{1'b0}};
         r_count   <= CNT_ZERO;
         alu_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr    <= r_rptr + PTR_ONE;
            OPCODE    <= w_head[EW-1 -: CODEW];
            OP1       <= w_head[2*OPW-1 -: OPW];
            OP2       <= w_head[OPW-1:0];
            alu_valid <= 1'b1;
         end else if (!alu_busy) begin
            alu_valid <= 1'b0;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef ALU_ISSUE_PERF_EN
   logic [15:0] r_issue_cnt;

   // Issued-operation counter; survives flush, wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_issue_cnt <= 16'd0;
      end else if (!flush && w_pop) begin
         r_issue_cnt <= r_issue_cnt + 16'd1;
      end
   end

   assign issue_cnt = r_issue_cnt;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: vector table, directed corner sequences and a
// randomized run compared against a queue-based reference model.
module tb_alu_op_issue;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_opcode = 3'd0;
   logic [3:0] in_op1 = 4'd0;
   logic [3:0] in_op2 = 4'd0;
   logic       alu_busy = 1'b0;
   logic [2:0] OPCODE;
   logic [3:0] OP1;
   logic [3:0] OP2;
   logic       alu_valid;
   logic [2:0] count;
`ifdef ALU_ISSUE_PERF_EN
   logic [15:0] issue_cnt;
`endif

   alu_op_issue #(.DEPTH(DEPTH), .OPW(4), .CODEW(3)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2), .alu_busy(alu_busy),
      .OPCODE(OPCODE), .OP1(OP1), .OP2(OP2), .alu_valid(alu_valid), .count(count)
`ifdef ALU_ISSUE_PERF_EN
      , .issue_cnt(issue_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a plain queue of pending ops plus the visible issue stage.
   logic [10:0] m_q[$];
   logic        m_valid = 1'b0;
   logic [2:0]  m_code = 3'd0;
   logic [3:0]  m_op1 = 4'd0;
   logic [3:0]  m_op2 = 4'd0;
   int          m_perf = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive at the falling edge, update model at the rising edge, check at the next falling edge.
   task automatic cyc(input logic r, input logic fl, input logic v, input logic [2:0] c,
                      input logic [3:0] a, input logic [3:0] b, input logic bz);
      logic [10:0] e;
      bit do_pop, do_push;
      rst = r; flush = fl; in_valid = v; in_opcode = c; in_op1 = a; in_op2 = b; alu_busy = bz;
      @(posedge clk);
      if (r) begin
         m_q.delete(); m_valid = 1'b0; m_code = 3'd0; m_op1 = 4'd0; m_op2 = 4'd0; m_perf = 0;
      end else if (fl) begin
         m_q.delete(); m_valid = 1'b0;
      end else begin
         do_pop  = !bz && (m_q.size() != 0);
         do_push = v && (m_q.size() != DEPTH);
         if (do_pop) begin
            e = m_q.pop_front();
            {m_code, m_op1, m_op2} = e;
            m_valid = 1'b1;
            m_perf = (m_perf + 1) % 65536;
         end else if (!bz) begin
            m_valid = 1'b0;
         end
         if (do_push) m_q.push_back({c, a, b});
      end
      @(negedge clk);
      chk("model_count", count, m_q.size());
      chk("model_in_ready", in_ready, (m_q.size() != DEPTH) ? 1 : 0);
      chk("model_valid", alu_valid, m_valid);
      chk("model_opcode", OPCODE, m_code);
      chk("model_op1", OP1, m_op1);
      chk("model_op2", OP2, m_op2);
`ifdef ALU_ISSUE_PERF_EN
      chk("model_issue_cnt", issue_cnt, m_perf);
`endif
   endtask

   typedef struct {
      logic v; logic [2:0] c; logic [3:0] a; logic [3:0] b; logic bz; logic fl;
      logic ev; logic [2:0] ec; logic [3:0] e1; logic [3:0] e2; int ecnt;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int k, t_acc, run, best_run;
      int seq[$];
      logic acc;

      // single op, busy hold, then flush with a concurrent push
      tbl[0]  = '{1'b1, 3'd7, 4'd4, 4'd10, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0,  4'd0, 1};
      tbl[1]  = '{1'b0, 3'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 3'd7, 4'd4,  4'd10, 0};
      tbl[2]  = '{1'b0, 3'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 3'd7, 4'd4,  4'd10, 0};
      tbl[3]  = '{1'b1, 3'd2, 4'd3, 4'd5,  1'b0, 1'b0, 1'b0, 3'd7, 4'd4,  4'd10, 1};
      tbl[4]  = '{1'b1, 3'd1, 4'd1, 4'd1,  1'b0, 1'b0, 1'b1, 3'd2, 4'd3,  4'd5, 1};
      tbl[5]  = '{1'b1, 3'd4, 4'd6, 4'd7,  1'b1, 1'b0, 1'b1, 3'd2, 4'd3,  4'd5, 2};
      tbl[6]  = '{1'b0, 3'd0, 4'd0, 4'd0,  1'b1, 1'b0, 1'b1, 3'd2, 4'd3,  4'd5, 2};
      tbl[7]  = '{1'b0, 3'd0, 4'd0, 4'd0,  1'b1, 1'b0, 1'b1, 3'd2, 4'd3,  4'd5, 2};
      tbl[8]  = '{1'b0, 3'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 3'd1, 4'd1,  4'd1, 1};
      tbl[9]  = '{1'b0, 3'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 3'd4, 4'd6,  4'd7, 0};
      tbl[10] = '{1'b0, 3'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 3'd4, 4'd6,  4'd7, 0};
      tbl[11] = '{1'b1, 3'd3, 4'd1, 4'd2,  1'b1, 1'b0, 1'b0, 3'd4, 4'd6,  4'd7, 1};
      tbl[12] = '{1'b1, 3'd5, 4'd2, 4'd3,  1'b1, 1'b0, 1'b0, 3'd4, 4'd6,  4'd7, 2};
      tbl[13] = '{1'b1, 3'd6, 4'd4, 4'd4,  1'b1, 1'b0, 1'b0, 3'd4, 4'd6,  4'd7, 3};
      tbl[14] = '{1'b1, 3'd7, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0, 3'd4, 4'd6, 4'd7, 0};
      tbl[15] = '{1'b0, 3'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 3'd4, 4'd6,  4'd7, 0};

      cyc(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
      chk("reset_valid", alu_valid, 0);
      chk("reset_opcode", OPCODE, 0);
      chk("reset_op1", OP1, 0);
      chk("reset_op2", OP2, 0);
      chk("reset_count", count, 0);
      chk("reset_in_ready", in_ready, 1);

      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, tbl[i].fl, tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].bz);
         chk($sformatf("tbl%0d_valid", i), alu_valid, tbl[i].ev);
         chk($sformatf("tbl%0d_opcode", i), OPCODE, tbl[i].ec);
         chk($sformatf("tbl%0d_op1", i), OP1, tbl[i].e1);
         chk($sformatf("tbl%0d_op2", i), OP2, tbl[i].e2);
         chk($sformatf("tbl%0d_count", i), count, tbl[i].ecnt);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, (tbl[i].ecnt != DEPTH) ? 1 : 0);
      end

      // Fill under stall: five offers, upstream holds the one not accepted
      k = 0;
      for (int t = 0; t < 6 && k < 5; t++) begin
         acc = in_ready;
         cyc(1'b0, 1'b0, 1'b1, 3'(k + 1), 4'(k), 4'(15 - k), 1'b1);
         if (acc) k++;
      end
      chk("fill_accepted", k, 4);
      chk("fill_count", count, 4);
      chk("fill_in_ready", in_ready, 0);
      t_acc = -1;
      seq.delete();
      for (int t = 0; t < 10; t++) begin
         acc = in_ready;
         cyc(1'b0, 1'b0, (k < 5), 3'(k + 1), 4'(k), 4'(15 - k), 1'b0);
         if (acc && k < 5) begin k++; t_acc = t; end
         if (alu_valid) seq.push_back(OPCODE);
      end
      chk("fill_fifth_accept_cycle", t_acc, 1);
      chk("fill_issue_len", seq.size(), 5);
      for (int i = 0; i < seq.size() && i < 5; i++) chk("fill_issue_order", seq[i], i + 1);

      // Back-to-back streaming of opcodes 0..7
      seq.delete(); run = 0; best_run = 0;
      for (int t = 0; t < 11; t++) begin
         cyc(1'b0, 1'b0, (t < 8), 3'(t), 4'(t), 4'(t + 8), 1'b0);
         chk("stream_count_le1", (count <= 1) ? 1 : 0, 1);
         if (alu_valid) begin seq.push_back(OPCODE); run++; end
         else run = 0;
         if (run > best_run) best_run = run;
      end
      chk("stream_valid_run", best_run, 8);
      chk("stream_len", seq.size(), 8);
      for (int i = 0; i < seq.size() && i < 8; i++) chk("stream_order", seq[i], i);

      // Randomized traffic against the model
      for (int t = 0; t < 1500; t++) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 3) != 0), 3'($urandom), 4'($urandom), 4'($urandom),
             ($urandom_range(0, 2) == 0));
      end

`ifdef ALU_ISSUE_PERF_EN
      cyc(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
      for (int i = 0; i < 65537; i++) cyc(1'b0, 1'b0, 1'b1, 3'(i), 4'(i), 4'(i), 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
      chk("perf_wrap", issue_cnt, 1);
      cyc(1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
      chk("perf_flush_hold", issue_cnt, 1);
      cyc(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
      chk("perf_reset", issue_cnt, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
